// File: rtl/layer_input_feeder.sv
`default_nettype none
//------------------------------------------------------------------------------
// layer_input_feeder: assembles byte-serial activations into a shadow frame and
// commits it, held stable, onto a layer's parallel node inputs.
// Revision: 1.0
//------------------------------------------------------------------------------
module layer_input_feeder #(
  parameter int N_IN     = 15,
  parameter int DATA_W   = 8,
  parameter int NODE_LAT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [N_IN*DATA_W-1:0]    a_vec,
  output logic                      vec_valid,
  output logic                      res_valid,
  output logic                      frame_err
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int LAT_W = (NODE_LAT > 0) ? $clog2(NODE_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [LAT_W-1:0] C_LAT      = LAT_W'(NODE_LAT);
  localparam logic [LAT_W-1:0] C_LAT_ONE  = LAT_W'(1);

  logic [DATA_W-1:0]      r_shadow [N_IN];
  logic [IDX_W-1:0]       r_idx;
  logic                   r_full;
  logic [LAT_W-1:0]       r_lat;
  logic [N_IN*DATA_W-1:0] w_shadow_flat;
  logic                   w_accept;
  logic                   w_commit;

  // The shadow keeps filling while the nodes compute on the committed vector.
  assign s_ready  = !reset && !r_full;
  assign w_accept = s_valid && s_ready;
  assign w_commit = r_full && (r_lat == '0);

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_flat
    assign w_shadow_flat[gi*DATA_W +: DATA_W] = r_shadow[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) r_shadow[i] <= '0;
      r_idx     <= '0;
      r_full    <= 1'b0;
      r_lat     <= '0;
      a_vec     <= '0;
      vec_valid <= 1'b0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;

      if (w_accept) begin
        r_shadow[r_idx] <= s_data;
        if (r_idx == C_IDX_LAST) begin
          r_idx <= '0;
          if (s_last) r_full    <= 1'b1;
          else        frame_err <= 1'b1;
        end else if (s_last) begin
          r_idx     <= '0;
          frame_err <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end

      // Commit and accept never coincide: a commit needs r_full, which blocks s_ready.
      if (w_commit) begin
        a_vec     <= w_shadow_flat;
        r_full    <= 1'b0;
        vec_valid <= 1'b1;
        r_lat     <= C_LAT;
      end else if (r_lat != '0) begin
        r_lat <= r_lat - 1'b1;
        if (r_lat == C_LAT_ONE) res_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
